ooo_dmem_responder: RTL

Memory-side responder for the execution unit's data memory request/response interface. It accepts load/store requests on a valid/ready handshake, buffers them in an in-order request FIFO, and services them one at a time against a word-addressed memory array with configurable access latency. Each load returns exactly one single-cycle mem_resp_valid pulse. Stores are silent. It serves as the data-memory model in core-level simulation and as the template for the real data cache front-end.

---
 rtl/ooo_mem_pkg.sv | 23 ++
 rtl/ooo_req_fifo.sv | 66 ++++++
 rtl/ooo_dmem_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/ooo_mem_pkg.sv
// Shared types for the data-memory request/response path.
//   mem_req_t   : one buffered request {is_load, addr, data} at the default widths
//   svc_state_e : service FSM states of the responder
//   MEM_IDX_W   : word-index width for the default memory depth
package ooo_mem_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_MEM_WORDS  = 1024;
    localparam int unsigned MEM_IDX_W      = $clog2(DEF_MEM_WORDS);

    typedef struct packed {
        logic                      is_load;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] data;
    } mem_req_t;

    typedef enum logic {
        IDLE,
        ACCESS
    } svc_state_e;

endpackage

// File: rtl/ooo_req_fifo.sv
// In-order request buffer for the data-memory responder.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset (flushes pointers/count)
//   push, push_data     : write one entry (ignored when full)
//   pop, pop_data       : consume the head entry; pop_data shows the head combinationally
//   full, empty, count  : occupancy; count is one bit wider than the pointers
import ooo_mem_pkg::*;

module ooo_req_fifo #(
    parameter type         entry_t = mem_req_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t           slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = slots[rd_ptr];

    // Storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ooo_dmem_responder.sv
// Memory-side responder for the execution unit's data-memory interface.
// Requests are buffered in order and serviced one at a time against a
// word-addressed array with a fixed access latency; each load produces one
// single-cycle response pulse, stores are silent.
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   mem_req_valid/ready           : request handshake (ready only from registered count)
//   mem_req_is_load/addr/data     : request payload (data ignored for loads)
//   mem_resp_valid, mem_resp_data : load completion pulse and held load data
//   busy                          : requests buffered or a request in service
module ooo_dmem_responder
    import ooo_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned MEM_WORDS      = DEF_MEM_WORDS,
    parameter int unsigned LATENCY        = 2,
    parameter int unsigned REQ_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req_valid,
    input  logic                  mem_req_is_load,
    input  logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic [DATA_WIDTH-1:0] mem_req_data,
    output logic                  mem_req_ready,
    output logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  mem_resp_valid,
    output logic                  busy
);

    localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
    localparam int unsigned CNT_W  = $clog2(LATENCY);
    localparam int unsigned FCNT_W = $clog2(REQ_FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CD_RELOAD = CNT_W'(LATENCY - 2);

    typedef struct packed {
        logic                  is_load;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t              push_req;
    req_t              head_req;
    req_t              svc_q;
    logic              push;
    logic              pop;
    logic              fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic              unused_fifo_full;
    logic              unused_svc_addr;

    svc_state_e        state;
    logic [CNT_W-1:0]  countdown;
    logic              access_now;
    logic              store_now;
    logic [IDX_W-1:0]  svc_idx;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    always_comb begin
        push_req         = '0;
        push_req.is_load = mem_req_is_load;
        push_req.addr    = mem_req_addr;
        push_req.data    = mem_req_data;
    end

    assign mem_req_ready = rst_n && (fifo_count < FCNT_W'(REQ_FIFO_DEPTH));
    assign push          = mem_req_valid && mem_req_ready;

    assign access_now = (state == ACCESS) && (countdown == '0);
    assign store_now  = access_now && !svc_q.is_load;
    // Pop when idle, or on the access edge so the next request starts without a bubble.
    assign pop        = !fifo_empty && ((state == IDLE) || access_now);

    // Byte offset and bits above the array depth are dropped: addresses wrap.
    assign svc_idx         = svc_q.addr[IDX_W+1:2];
    assign unused_svc_addr = ^svc_q.addr;

    assign busy = !fifo_empty || (state != IDLE);

    ooo_req_fifo #(
        .entry_t (req_t),
        .DEPTH   (REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_req),
        .pop       (pop),
        .pop_data  (head_req),
        .full      (unused_fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Array write lives outside the reset block; the FSM reset alone blocks
    // any pending store from landing.
    always_ff @(posedge clk) begin
        if (store_now) begin
            mem[svc_idx] <= svc_q.data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            countdown      <= '0;
            svc_q          <= '0;
            mem_resp_valid <= 1'b0;
            mem_resp_data  <= '0;
        end else begin
            mem_resp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        svc_q     <= head_req;
                        countdown <= CD_RELOAD;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (countdown != '0) begin
                        countdown <= countdown - CNT_W'(1);
                    end else begin
                        if (svc_q.is_load) begin
                            mem_resp_data  <= mem[svc_idx];
                            mem_resp_valid <= 1'b1;
                        end
                        if (!fifo_empty) begin
                            svc_q     <= head_req;
                            countdown <= CD_RELOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
